divider: RTL and testbench

- Multi-cycle unsigned integer divider using a radix-2 restoring algorithm, producing one quotient bit per clock.
- Accepts a single-cycle start pulse with dividend and divisor.
- Returns quotient and remainder with a one-cycle done pulse.
- Used as a shared arithmetic co-processor block: one operation in flight, no pipelining.

---
 rtl/divider.sv | 136 +++++++++++++
 tb/tb_divider.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin a division (accepted only in IDLE)
//   dividend    unsigned dividend, sampled when start is accepted
//   divisor     unsigned divisor, sampled when start is accepted
//   done        one-cycle pulse, result valid
//   quotient    registered unsigned quotient
//   remainder   registered unsigned remainder
//   div_by_zero registered flag, latched divisor was zero
//               (present only when DIVIDER_DBZ_FLAG_EN is defined)
//
// Optional feature macro: DIVIDER_DBZ_FLAG_EN
//
// Latency: start accepted at edge k, done high in the cycle after edge
// k+WIDTH+1. Divide by zero yields quotient all ones, remainder = dividend.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_div;   // latched divisor
  logic [WIDTH-1:0] r_dq;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_rem;   // partial remainder
  logic [CW-1:0]    r_cnt;   // iterations left
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic             r_dbz;
`endif

  logic [WIDTH:0]   w_shift;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;

  // Trial subtraction: the comparison is done at WIDTH+1 bits so the shifted
  // partial remainder cannot overflow. When it succeeds the true difference is
  // below the divisor, so the low WIDTH bits of a WIDTH-bit subtract are exact.
  always_comb begin
    w_shift    = {r_rem, r_dq[WIDTH-1]};
    w_qbit     = (w_shift >= {1'b0, r_div});
    w_rem_next = w_qbit ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // BUSY iterates while the counter is non-zero; the edge that finds it at
  // zero copies the result out, which places done after edge k+WIDTH+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_dq   <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
`ifdef DIVIDER_DBZ_FLAG_EN
      r_dbz  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div <= divisor;
            r_dq  <= dividend;
            r_rem <= '0;
            r_cnt <= CW'(WIDTH);
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_rem <= w_rem_next;
            r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_quot <= r_dq;
            r_remo <= r_rem;
`ifdef DIVIDER_DBZ_FLAG_EN
            r_dbz  <= (r_div == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = (r_state == S_DONE);
  assign quotient  = r_quot;
  assign remainder = r_remo;
`ifdef DIVIDER_DBZ_FLAG_EN
  assign div_by_zero = r_dbz;
`endif

endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for divider (WIDTH=32), directed cases plus
// randomized operands checked against plain integer division.
module tb_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic         div_by_zero;
`endif

  int n_total = 0;
  int n_bad   = 0;

  divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: ordinary integer division, divide by zero gives all ones / dividend.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // One operation: latency, result, single-cycle done, outputs held afterwards.
  // poke pulses start (50/3) while the operation is in flight.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int n;
    int extra;
    ref_div(a, b, eq, er);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    n = 0;
    while (!done && n < int'(W) + 10) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 4) begin
        start = 1'b1; dividend = 50; divisor = 3;
      end else begin
        start = 1'b0;
      end
    end
    // done becomes visible just after edge k+W+1
    check({tag, ":latency"}, 64'(n), 64'(W + 1));
    check({tag, ":done"}, 64'(done), 64'd1);
    check({tag, ":q"}, 64'(quotient), 64'(eq));
    check({tag, ":r"}, 64'(remainder), 64'(er));
`ifdef DIVIDER_DBZ_FLAG_EN
    check({tag, ":dbz"}, 64'(div_by_zero), 64'(b == '0));
`endif
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 64'(done), 64'd0);
    check({tag, ":q_hold"}, 64'(quotient), 64'(eq));
    check({tag, ":r_hold"}, 64'(remainder), 64'(er));
    if (poke) begin
      extra = 0;
      for (int i = 0; i < int'(W) + 8; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, ":no_second_done"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int extra;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst:done", 64'(done), 64'd0);
    check("rst:q", 64'(quotient), 64'd0);
    check("rst:r", 64'(remainder), 64'd0);
`ifdef DIVIDER_DBZ_FLAG_EN
    check("rst:dbz", 64'(div_by_zero), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    do_div(32'd10, 32'd7, 1'b0, "10/7");
    do_div(32'd100, 32'd100, 1'b0, "100/100");
    do_div(32'd100, 32'd7, 1'b0, "100/7");
    do_div(32'd70, 32'd150, 1'b0, "70/150");
    do_div(32'd100, 32'd0, 1'b0, "100/0");
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, "max/1");
    do_div(32'd0, 32'd5, 1'b0, "0/5");
    do_div(32'd0, 32'd0, 1'b0, "0/0");
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max/max");
    do_div(32'd1000, 32'd9, 1'b1, "busy_start");

    // Asynchronous reset between edges in the middle of an operation
    @(negedge clk);
    start = 1'b1; dividend = 32'd123456; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst:done", 64'(done), 64'd0);
    check("midrst:q", 64'(quotient), 64'd0);
    check("midrst:r", 64'(remainder), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < int'(W) + 8; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("midrst:no_done", 64'(extra), 64'd0);
    do_div(32'd9, 32'd4, 1'b0, "9/4");

    // Randomized operands with a spread of divisor magnitudes
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = 32'($urandom_range(1, 20));
        3: b = '0;
        default: begin
          b = $urandom;
          a = a >> $urandom_range(0, 31);
        end
      endcase
      do_div(a, b, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
